// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types and constants for the MIPS front end.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with load enable and bubble clear.
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    input  logic        i_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Clear beats enable so a redirect bubble always wins over a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= i_valid;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, instruction-memory request FSM and hold buffer feeding IF/ID.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_addr;
    logic         r_req;
    logic [31:0]  r_buf;

    logic         w_redirect;
    logic         w_ack;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_ifid_en;
    logic         w_ifid_clr;
    logic [31:0]  w_ifid_instr;
    logic [31:0]  w_ifid_pc4;
    logic         w_unused_lsbs;

    assign w_redirect    = PCSrcD & ~StallD;
    assign w_target      = {PCBranchD[31:2], 2'b00};
    assign w_unused_lsbs = ^PCBranchD[1:0];
    // An ack only counts against a request we actually issued.
    assign w_ack         = imem_ack & r_req;
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_ifid_pc4    = r_addr + 32'd4;

    always_comb begin
        w_ifid_en    = 1'b0;
        w_ifid_clr   = 1'b0;
        w_ifid_instr = imem_rdata;
        case (r_state)
            FETCH: begin
                if (w_redirect)
                    w_ifid_clr = 1'b1;
                else if (r_req && w_ack)
                    w_ifid_en = ~StallF & ~StallD;
                else
                    w_ifid_clr = ~StallD;
            end
            HOLD: begin
                if (w_redirect) begin
                    w_ifid_clr = 1'b1;
                end else if (!StallF && !StallD) begin
                    w_ifid_en    = 1'b1;
                    w_ifid_instr = r_buf;
                end
            end
            DRAIN:   w_ifid_clr = ~StallD;
            default: w_ifid_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_buf   <= NOP_INSTR;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!r_req) begin
                        // First cycle out of reset: issue the opening request.
                        r_req <= 1'b1;
                        if (w_redirect) begin
                            r_pc   <= w_target;
                            r_addr <= w_target;
                        end else begin
                            r_addr <= r_pc;
                        end
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                        if (w_ack)
                            r_addr <= w_target;
                        else
                            r_state <= DRAIN;
                    end else if (w_ack) begin
                        if (!StallF && !StallD) begin
                            r_pc   <= w_pc_plus4;
                            r_addr <= w_pc_plus4;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_req   <= 1'b0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_buf   <= NOP_INSTR;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end else if (!StallF && !StallD) begin
                        r_pc    <= w_pc_plus4;
                        r_addr  <= w_pc_plus4;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (w_redirect)
                        r_pc <= w_target;
                    if (w_ack) begin
                        r_addr  <= w_redirect ? w_target : r_pc;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= FETCH;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_ifid_en),
        .i_clr   (w_ifid_clr),
        .i_instr (w_ifid_instr),
        .i_pc4   (w_ifid_pc4),
        .i_valid (1'b1),
        .o_instr (InstrD),
        .o_pc4   (PCPlus4D),
        .o_valid (ValidD)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign PCF       = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, PCSrcD;
    logic [31:0] PCBranchD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;

    int n_tests  = 0;
    int n_failed = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
        PCBranchD = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        step(); step();
        check("rst_req",    {31'h0, imem_req}, 32'h0);
        check("rst_pcf",    PCF,      32'h0);
        check("rst_instr",  InstrD,   32'h0);
        check("rst_pc4",    PCPlus4D, 32'h0);
        check("rst_valid",  {31'h0, ValidD}, 32'h0);

        // Streaming fetch with single-cycle acks
        rst_n = 1'b1;
        step();
        check("start_req",  {31'h0, imem_req}, 32'h1);
        check("start_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        check("s1_instr", InstrD, 32'h1111_0000);
        check("s1_pc4",   PCPlus4D, 32'h4);
        check("s1_valid", {31'h0, ValidD}, 32'h1);
        check("s1_addr",  imem_addr, 32'h4);
        imem_rdata = 32'h1111_0004;
        step();
        check("s2_pc4",  PCPlus4D, 32'h8);
        check("s2_addr", imem_addr, 32'h8);
        imem_rdata = 32'h1111_0008;
        step();
        check("s3_pc4",  PCPlus4D, 32'hC);
        check("s3_pcf",  PCF, 32'hC);

        // Stall while the ack arrives: word parked in the hold buffer
        StallF = 1'b1; StallD = 1'b1; imem_rdata = 32'h8C01_0004;
        step();
        imem_ack = 1'b0;
        check("hold_req",   {31'h0, imem_req}, 32'h0);
        check("hold_instr", InstrD, 32'h1111_0008);
        check("hold_pcf",   PCF, 32'hC);
        step();
        check("hold2_req",   {31'h0, imem_req}, 32'h0);
        check("hold2_pc4",   PCPlus4D, 32'hC);
        StallF = 1'b0; StallD = 1'b0;
        step();
        check("rel_instr", InstrD, 32'h8C01_0004);
        check("rel_valid", {31'h0, ValidD}, 32'h1);
        check("rel_pc4",   PCPlus4D, 32'h10);
        check("rel_pcf",   PCF, 32'h10);
        check("rel_addr",  imem_addr, 32'h10);

        // Redirect without ack: drain the old request
        PCSrcD = 1'b1; PCBranchD = 32'h0000_0043;
        step();
        PCSrcD = 1'b0;
        check("drn_pcf",   PCF, 32'h40);
        check("drn_addr",  imem_addr, 32'h10);
        check("drn_req",   {31'h0, imem_req}, 32'h1);
        check("drn_valid", {31'h0, ValidD}, 32'h0);
        step();
        check("drn2_valid", {31'h0, ValidD}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("drn_done_addr",  imem_addr, 32'h40);
        check("drn_done_valid", {31'h0, ValidD}, 32'h0);
        check("drn_done_instr", InstrD, 32'h0);
        imem_rdata = 32'h3333_0000;
        step();
        check("tgt_instr", InstrD, 32'h3333_0000);
        check("tgt_pc4",   PCPlus4D, 32'h44);
        check("tgt_addr",  imem_addr, 32'h44);

        // PCSrcD during StallD is ignored
        PCSrcD = 1'b1; PCBranchD = 32'h0000_0100; StallD = 1'b1; StallF = 1'b1; imem_ack = 1'b0;
        step();
        check("ign_pcf",   PCF, 32'h44);
        check("ign_instr", InstrD, 32'h3333_0000);
        check("ign_pc4",   PCPlus4D, 32'h44);
        check("ign_addr",  imem_addr, 32'h44);

        // Redirect with same-cycle ack, then wrap past 2^32
        StallD = 1'b0; StallF = 1'b0;
        PCBranchD = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        PCSrcD = 1'b0;
        check("redir_pcf",   PCF, 32'hFFFF_FFFC);
        check("redir_addr",  imem_addr, 32'hFFFF_FFFC);
        check("redir_valid", {31'h0, ValidD}, 32'h0);
        imem_rdata = 32'h4444_0000;
        step();
        check("wrap_instr", InstrD, 32'h4444_0000);
        check("wrap_pc4",   PCPlus4D, 32'h0);
        check("wrap_addr",  imem_addr, 32'h0);
        imem_rdata = 32'h5555_0000;
        step();
        check("post_wrap_pcf", PCF, 32'h4);
        imem_ack = 1'b0;
        step();
        check("bubble_valid", {31'h0, ValidD}, 32'h0);

        // Reset while awaiting ack, with a late ack across the release
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   {31'h0, imem_req}, 32'h0);
        check("mid_rst_pcf",   PCF, 32'h0);
        check("mid_rst_instr", InstrD, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
        step();
        rst_n = 1'b1;
        step();
        check("restart_req",   {31'h0, imem_req}, 32'h1);
        check("restart_addr",  imem_addr, 32'h0);
        check("late_ack_valid", {31'h0, ValidD}, 32'h0);
        check("late_ack_instr", InstrD, 32'h0);
        imem_rdata = 32'h6666_0000;
        step();
        check("restart_instr", InstrD, 32'h6666_0000);
        check("restart_pc4",   PCPlus4D, 32'h4);
        check("restart_valid", {31'h0, ValidD}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n input 1: asynchronous, active-low reset.
REQ-004 Port StallF input 1: hazard-logic request to hold PC.
REQ-005 Port StallD input 1: hazard-logic request to hold the IF/ID register.
REQ-006 Port PCSrcD input 1: branch taken, resolved in decode.
REQ-007 Port PCBranchD input 32: branch target.
REQ-008 Port imem_req output 1: instruction-memory request.
REQ-009 Port imem_addr output 32: request address.
REQ-010 Port imem_ack input 1: read data valid this cycle.
REQ-011 Port imem_rdata input 32: instruction word.
REQ-012 Port PCF output 32: current fetch PC.
REQ-013 Port InstrD output 32: IF/ID instruction.
REQ-014 Port PCPlus4D output 32: IF/ID fetched address + 4.
REQ-015 Port ValidD output 1: IF/ID holds a real instruction; 0 = bubble.

Function
REQ-016 States SHALL be FETCH, HOLD and DRAIN.
REQ-017 imem_addr SHALL come from a register loaded at request issue, and SHALL stay stable while imem_req=1 until imem_ack.
REQ-018 FETCH: imem_req=1.
- ack & !StallF & !StallD: IF/ID <= {rdata, addr+4, valid=1}; PC <= PC+4; next request to the new PC; stay in FETCH.
- ack & (StallF | StallD): word -> hold buffer; IF/ID unchanged; PC unchanged; go to HOLD.
- no ack & !StallD: IF/ID <= bubble (InstrD=0, ValidD=0).
- no ack & StallD: IF/ID unchanged.
REQ-019 HOLD: imem_req=0; when StallF=0 and StallD=0, IF/ID <= buffer (valid=1), PC <= PC+4, go to FETCH.
REQ-020 Redirect is defined as PCSrcD=1 & StallD=0; PCSrcD with StallD=1 SHALL be ignored.
REQ-021 On redirect:
- PC <= {PCBranchD[31:2], 2'b00}.
- IF/ID <= bubble.
- From HOLD: the buffer is dropped; go to FETCH.
- From FETCH with ack the same cycle: the word is discarded; go to FETCH.
- From FETCH without ack: go to DRAIN.
REQ-022 DRAIN: imem_req=1 with the old address; on ack the word is discarded and the state goes to FETCH at PC; a further redirect in DRAIN only updates PC; IF/ID <= bubble unless StallD.
REQ-023 Redirect SHALL take priority over the StallF hold of PC.
REQ-024 PC and PCPlus4D arithmetic SHALL be 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-025 Latency: with imem_ack in the same cycle as the request, one instruction SHALL enter IF/ID per unstalled cycle.

Reset
REQ-026 While rst_n=0:
- PC = RESET_PC, state = FETCH, imem_req = 0.
- InstrD = 0, PCPlus4D = 0, ValidD = 0, hold buffer cleared.
REQ-027 imem_req SHALL assert in the first cycle after rst_n rises, with imem_addr = RESET_PC.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request; a late ack after reset SHALL be ignored until a new request is issued.

Structure
REQ-029 Shared package mips_pkg SHALL hold:
- fetch_state_t (FETCH, HOLD, DRAIN)
- NOP_INSTR = 32'h0
- the default RESET_PC
REQ-030 The IF/ID register (enable, clear, async reset) SHALL be the sub-module if_id_reg; the FSM, PC and buffer live in fetch_unit.

Verification
REQ-031 Reset release, ack every cycle -> imem_addr 0,4,8; ValidD=1 from cycle 2; PCPlus4D 4,8,12.
REQ-032 StallF=StallD=1 for 2 cycles while ack arrives with 32'h8C01_0004 -> HOLD, imem_req=0, IF/ID frozen; after release InstrD=32'h8C01_0004, PC advances by 4.
REQ-033 PCSrcD=1, PCBranchD=32'h0000_0043, StallD=0, ack held low -> DRAIN; old-address ack discarded; next imem_addr=32'h0000_0040; ValidD=0 throughout.
REQ-034 PCSrcD=1 with StallD=1 -> no redirect; PC unchanged; IF/ID held.
REQ-035 PC=32'hFFFF_FFFC, ack -> PCPlus4D=0, next imem_addr=0.
REQ-036 rst_n pulsed low while awaiting ack -> outputs at reset values; fetch restarts at RESET_PC.
